// File: rtl/m_ifetch_queue.sv
// Instruction fetch front end: one outstanding imem request feeding a small
// (pc, ir) FIFO toward ID, flushed by taken branches/jumps from ID.
module m_ifetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        w_clk,
    input  logic        w_rst_n,
    input  logic        w_redirect,
    input  logic [31:0] w_redirect_pc,
    output logic        w_imem_req,
    output logic [31:0] w_imem_addr,
    input  logic        w_imem_gnt,
    input  logic        w_imem_rvalid,
    input  logic [31:0] w_imem_rdata,
    output logic        w_out_valid,
    input  logic        w_out_ready,
    output logic [31:0] w_out_ir,
    output logic [31:0] w_out_pc,
    output logic [31:0] w_out_npc
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DROP = 2'd2;

    logic [1:0]       state_q,    state_d;
    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      req_pc_q,   req_pc_d;
    logic [CNT_W-1:0] count_q,    count_d;
    logic [PTR_W-1:0] rd_ptr_q,   rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q,   wr_ptr_d;

    logic [31:0] pc_mem [DEPTH];
    logic [31:0] ir_mem [DEPTH];

    logic grant;
    logic push;
    logic pop;

    // Credit check uses the committed count only; the single outstanding
    // request always lands in the slot that was free when it was issued.
    assign w_imem_req  = w_rst_n && (state_q == S_IDLE) && (count_q < DEPTH_C) && !w_redirect;
    assign w_imem_addr = fetch_pc_q;

    assign grant = w_imem_req && w_imem_gnt;
    assign push  = (state_q == S_WAIT) && w_imem_rvalid && !w_redirect;
    assign pop   = w_out_valid && w_out_ready && !w_redirect;

    assign w_out_valid = (count_q != '0);
    assign w_out_ir    = w_out_valid ? ir_mem[rd_ptr_q] : 32'h0000_0013;
    assign w_out_pc    = w_out_valid ? pc_mem[rd_ptr_q] : 32'h0;
    assign w_out_npc   = w_out_pc + 32'd4;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;

        case (state_q)
            S_IDLE: begin
                if (grant) begin
                    state_d    = S_WAIT;
                    req_pc_d   = fetch_pc_q;
                    fetch_pc_d = fetch_pc_q + 32'd4;
                end
            end
            S_WAIT: begin
                if (w_imem_rvalid) begin
                    state_d = S_IDLE;
                end else if (w_redirect) begin
                    state_d = S_DROP;
                end
            end
            S_DROP: begin
                if (w_imem_rvalid) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end

        // A redirect wins over any push/pop in the same cycle.
        if (w_redirect) begin
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            fetch_pc_d = w_redirect_pc;
        end
    end

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= RESET_PC;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    always_ff @(posedge w_clk) begin
        if (push) begin
            pc_mem[wr_ptr_q] <= req_pc_q;
            ir_mem[wr_ptr_q] <= w_imem_rdata;
        end
    end

endmodule

// File: tb/tb_m_ifetch_queue.sv
// Directed bench for m_ifetch_queue: a latency-1 memory model (or manual
// response control) plus one task per scenario with inline expected values.
module tb_m_ifetch_queue;

    logic        w_clk;
    logic        w_rst_n;
    logic        w_redirect;
    logic [31:0] w_redirect_pc;
    logic        w_imem_req;
    logic [31:0] w_imem_addr;
    logic        w_imem_gnt;
    logic        w_imem_rvalid;
    logic [31:0] w_imem_rdata;
    logic        w_out_valid;
    logic        w_out_ready;
    logic [31:0] w_out_ir;
    logic [31:0] w_out_pc;
    logic [31:0] w_out_npc;

    logic        mem_auto;
    logic        auto_rvalid;
    logic [31:0] auto_rdata;
    logic        man_rvalid;
    logic [31:0] man_rdata;

    int tests_run;
    int tests_failed;

    assign w_imem_rvalid = mem_auto ? auto_rvalid : man_rvalid;
    assign w_imem_rdata  = mem_auto ? auto_rdata  : man_rdata;

    m_ifetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .w_clk         (w_clk),
        .w_rst_n       (w_rst_n),
        .w_redirect    (w_redirect),
        .w_redirect_pc (w_redirect_pc),
        .w_imem_req    (w_imem_req),
        .w_imem_addr   (w_imem_addr),
        .w_imem_gnt    (w_imem_gnt),
        .w_imem_rvalid (w_imem_rvalid),
        .w_imem_rdata  (w_imem_rdata),
        .w_out_valid   (w_out_valid),
        .w_out_ready   (w_out_ready),
        .w_out_ir      (w_out_ir),
        .w_out_pc      (w_out_pc),
        .w_out_npc     (w_out_npc)
    );

    initial begin
        w_clk = 1'b0;
        forever #5 w_clk = ~w_clk;
    end

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return 32'hC0DE_0000 ^ a;
    endfunction

    // Memory model: a grant seen before an edge answers in the following cycle.
    initial begin
        logic        nxt;
        logic [31:0] a;
        auto_rvalid = 1'b0;
        auto_rdata  = 32'h0;
        forever begin
            @(negedge w_clk);
            nxt = w_imem_req && w_imem_gnt;
            a   = w_imem_addr;
            @(posedge w_clk);
            #1;
            auto_rvalid = nxt;
            auto_rdata  = nxt ? word_of(a) : 32'h0;
        end
    end

    task automatic tick;
        @(posedge w_clk);
        #1;
    endtask

    task automatic apply_reset(input logic auto_mode);
        w_rst_n       = 1'b0;
        w_redirect    = 1'b0;
        w_redirect_pc = 32'h0;
        w_out_ready   = 1'b0;
        w_imem_gnt    = 1'b1;
        mem_auto      = auto_mode;
        man_rvalid    = 1'b0;
        man_rdata     = 32'h0;
        tick();
        tick();
        w_rst_n = 1'b1;
    endtask

    // Leaves two entries (pc 0 and 4) queued, IDLE, requesting addr 8.
    task automatic fill_two_manual;
        tick();
        man_rvalid = 1'b1;
        man_rdata  = word_of(32'h0);
        tick();
        man_rvalid = 1'b0;
        tick();
        man_rvalid = 1'b1;
        man_rdata  = word_of(32'h4);
        tick();
        man_rvalid = 1'b0;
    endtask

    task automatic test_reset;
        w_rst_n       = 1'b0;
        w_redirect    = 1'b0;
        w_redirect_pc = 32'h0;
        w_out_ready   = 1'b0;
        w_imem_gnt    = 1'b1;
        mem_auto      = 1'b1;
        man_rvalid    = 1'b0;
        man_rdata     = 32'h0;
        tick();
        #1;
        tests_run++;
        if (w_imem_req !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_req: got %b expected 0", w_imem_req);
        end
        tests_run++;
        if (w_out_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_valid: got %b expected 0", w_out_valid);
        end
        tests_run++;
        if (w_out_ir !== 32'h13) begin
            tests_failed++;
            $display("[TB] FAIL reset_ir: got %h expected 00000013", w_out_ir);
        end
        tests_run++;
        if (w_out_pc !== 32'h0 || w_out_npc !== 32'h4) begin
            tests_failed++;
            $display("[TB] FAIL reset_pc_npc: got %h/%h expected 00000000/00000004", w_out_pc, w_out_npc);
        end
        tick();
        w_rst_n = 1'b1;
        #1;
        tests_run++;
        if (w_imem_req !== 1'b1 || w_imem_addr !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL first_req: got req=%b addr=%h expected req=1 addr=00000000", w_imem_req, w_imem_addr);
        end
    endtask

    task automatic test_streaming;
        int seen;
        int last_cyc;
        apply_reset(1'b1);
        w_out_ready = 1'b1;
        seen = 0;
        last_cyc = 0;
        for (int cyc = 0; cyc < 30 && seen < 4; cyc++) begin
            @(negedge w_clk);
            if (w_out_valid) begin
                tests_run++;
                if (w_out_pc !== 32'(seen * 4) || w_out_ir !== word_of(32'(seen * 4)) || w_out_npc !== 32'(seen * 4 + 4)) begin
                    tests_failed++;
                    $display("[TB] FAIL stream_entry%0d: got pc=%h ir=%h npc=%h expected pc=%h ir=%h npc=%h", seen, w_out_pc, w_out_ir, w_out_npc, 32'(seen * 4), word_of(32'(seen * 4)), 32'(seen * 4 + 4));
                end
                if (seen > 0) begin
                    tests_run++;
                    if (cyc - last_cyc != 2) begin
                        tests_failed++;
                        $display("[TB] FAIL stream_rate%0d: got gap %0d expected 2", seen, cyc - last_cyc);
                    end
                end
                last_cyc = cyc;
                seen++;
            end
        end
        tests_run++;
        if (seen != 4) begin
            tests_failed++;
            $display("[TB] FAIL stream_count: got %0d expected 4", seen);
        end
    endtask

    task automatic test_fill;
        int pushes;
        int k;
        logic req_seen;
        apply_reset(1'b1);
        pushes = 0;
        repeat (20) begin
            @(negedge w_clk);
            if (w_imem_rvalid) pushes++;
        end
        tests_run++;
        if (pushes != 4) begin
            tests_failed++;
            $display("[TB] FAIL fill_pushes: got %0d expected 4", pushes);
        end
        tests_run++;
        if (w_imem_req !== 1'b0 || w_out_valid !== 1'b1 || w_out_pc !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL fill_full: got req=%b valid=%b pc=%h expected req=0 valid=1 pc=00000000", w_imem_req, w_out_valid, w_out_pc);
        end
        tick();
        w_out_ready = 1'b1;
        k = 0;
        req_seen = 1'b0;
        for (int cyc = 0; cyc < 30 && k < 6; cyc++) begin
            @(negedge w_clk);
            if (w_imem_req && !req_seen) begin
                req_seen = 1'b1;
                tests_run++;
                if (w_imem_addr !== 32'h10) begin
                    tests_failed++;
                    $display("[TB] FAIL fill_resume_addr: got %h expected 00000010", w_imem_addr);
                end
            end
            if (w_out_valid) begin
                tests_run++;
                if (w_out_pc !== 32'(k * 4)) begin
                    tests_failed++;
                    $display("[TB] FAIL fill_drain%0d: got pc=%h expected %h", k, w_out_pc, 32'(k * 4));
                end
                k++;
            end
        end
        tests_run++;
        if (k != 6 || !req_seen) begin
            tests_failed++;
            $display("[TB] FAIL fill_drain_count: got %0d entries req_seen=%b expected 6 entries req_seen=1", k, req_seen);
        end
    endtask

    task automatic test_redirect_wait;
        apply_reset(1'b0);
        fill_two_manual();
        #1;
        tests_run++;
        if (w_imem_req !== 1'b1 || w_imem_addr !== 32'h8) begin
            tests_failed++;
            $display("[TB] FAIL rw_pre_req: got req=%b addr=%h expected req=1 addr=00000008", w_imem_req, w_imem_addr);
        end
        tick();
        w_redirect    = 1'b1;
        w_redirect_pc = 32'h100;
        #1;
        tests_run++;
        if (w_imem_req !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL rw_redirect_cycle_req: got %b expected 0", w_imem_req);
        end
        tick();
        w_redirect = 1'b0;
        #1;
        tests_run++;
        if (w_imem_req !== 1'b0 || w_out_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL rw_drop_flush: got req=%b valid=%b expected req=0 valid=0", w_imem_req, w_out_valid);
        end
        tick();
        man_rvalid = 1'b1;
        man_rdata  = word_of(32'h8);
        #1;
        tests_run++;
        if (w_imem_req !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL rw_drop_req: got %b expected 0", w_imem_req);
        end
        tick();
        man_rvalid = 1'b0;
        #1;
        tests_run++;
        if (w_imem_req !== 1'b1 || w_imem_addr !== 32'h100 || w_out_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL rw_after_drop: got req=%b addr=%h valid=%b expected req=1 addr=00000100 valid=0", w_imem_req, w_imem_addr, w_out_valid);
        end
        tick();
        man_rvalid = 1'b1;
        man_rdata  = word_of(32'h100);
        tick();
        man_rvalid = 1'b0;
        #1;
        tests_run++;
        if (w_out_valid !== 1'b1 || w_out_pc !== 32'h100 || w_out_ir !== word_of(32'h100) || w_out_npc !== 32'h104) begin
            tests_failed++;
            $display("[TB] FAIL rw_target_entry: got valid=%b pc=%h ir=%h npc=%h expected 1/00000100/%h/00000104", w_out_valid, w_out_pc, w_out_ir, w_out_npc, word_of(32'h100));
        end
    endtask

    task automatic test_redirect_pop;
        apply_reset(1'b0);
        fill_two_manual();
        tick();
        w_out_ready   = 1'b1;
        man_rvalid    = 1'b1;
        man_rdata     = word_of(32'h8);
        w_redirect    = 1'b1;
        w_redirect_pc = 32'h40;
        #1;
        tests_run++;
        if (w_out_valid !== 1'b1 || w_out_pc !== 32'h0 || w_imem_req !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL rp_pre: got valid=%b pc=%h req=%b expected valid=1 pc=00000000 req=0", w_out_valid, w_out_pc, w_imem_req);
        end
        tick();
        w_redirect = 1'b0;
        man_rvalid = 1'b0;
        #1;
        tests_run++;
        if (w_out_valid !== 1'b0 || w_out_ir !== 32'h13 || w_out_pc !== 32'h0 || w_out_npc !== 32'h4) begin
            tests_failed++;
            $display("[TB] FAIL rp_flushed: got valid=%b ir=%h pc=%h npc=%h expected 0/00000013/00000000/00000004", w_out_valid, w_out_ir, w_out_pc, w_out_npc);
        end
        tests_run++;
        if (w_imem_req !== 1'b1 || w_imem_addr !== 32'h40) begin
            tests_failed++;
            $display("[TB] FAIL rp_next_req: got req=%b addr=%h expected req=1 addr=00000040", w_imem_req, w_imem_addr);
        end
        tick();
        man_rvalid = 1'b1;
        man_rdata  = word_of(32'h40);
        tick();
        man_rvalid = 1'b0;
        #1;
        tests_run++;
        if (w_out_valid !== 1'b1 || w_out_pc !== 32'h40 || w_out_ir !== word_of(32'h40)) begin
            tests_failed++;
            $display("[TB] FAIL rp_target_entry: got valid=%b pc=%h ir=%h expected 1/00000040/%h", w_out_valid, w_out_pc, w_out_ir, word_of(32'h40));
        end
    endtask

    task automatic test_wrap;
        int seen;
        apply_reset(1'b1);
        seen = 0;
        for (int cyc = 0; cyc < 200 && seen < 10; cyc++) begin
            w_out_ready = (cyc >= 8) && (cyc % 3 != 1);
            @(negedge w_clk);
            if (w_out_valid && w_out_ready) begin
                tests_run++;
                if (w_out_pc !== 32'(seen * 4) || w_out_ir !== word_of(32'(seen * 4))) begin
                    tests_failed++;
                    $display("[TB] FAIL wrap_entry%0d: got pc=%h ir=%h expected pc=%h ir=%h", seen, w_out_pc, w_out_ir, 32'(seen * 4), word_of(32'(seen * 4)));
                end
                seen++;
            end
            tick();
        end
        tests_run++;
        if (seen != 10) begin
            tests_failed++;
            $display("[TB] FAIL wrap_count: got %0d expected 10", seen);
        end
        w_out_ready = 1'b0;
    endtask

    task automatic test_async_reset;
        apply_reset(1'b1);
        tick();
        tick();
        tick();
        mem_auto   = 1'b0;
        man_rvalid = 1'b0;
        #1;
        tests_run++;
        if (w_out_valid !== 1'b1 || w_imem_req !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL ar_pre: got valid=%b req=%b expected valid=1 req=0", w_out_valid, w_imem_req);
        end
        w_rst_n = 1'b0;
        #1;
        tests_run++;
        if (w_imem_req !== 1'b0 || w_out_valid !== 1'b0 || w_out_ir !== 32'h13 || w_out_pc !== 32'h0 || w_out_npc !== 32'h4) begin
            tests_failed++;
            $display("[TB] FAIL ar_async: got req=%b valid=%b ir=%h pc=%h npc=%h expected 0/0/00000013/00000000/00000004", w_imem_req, w_out_valid, w_out_ir, w_out_pc, w_out_npc);
        end
        #1;
        w_rst_n = 1'b1;
        @(negedge w_clk);
        tests_run++;
        if (w_imem_req !== 1'b1 || w_imem_addr !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL ar_first_req: got req=%b addr=%h expected req=1 addr=00000000", w_imem_req, w_imem_addr);
        end
        tick();
        man_rvalid = 1'b1;
        man_rdata  = word_of(32'h0);
        tick();
        man_rvalid = 1'b0;
        #1;
        tests_run++;
        if (w_out_valid !== 1'b1 || w_out_pc !== 32'h0 || w_out_ir !== word_of(32'h0)) begin
            tests_failed++;
            $display("[TB] FAIL ar_first_entry: got valid=%b pc=%h ir=%h expected 1/00000000/%h", w_out_valid, w_out_pc, w_out_ir, word_of(32'h0));
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_streaming();
        test_fill();
        test_redirect_wait();
        test_redirect_pop();
        test_wrap();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
